// File: rtl/regfile_pkg.sv
// Shared definitions for the 32 x 8-bit register bank: write-op encodings,
// default geometry and the clear-sequencer state encoding.
package regfile_pkg;

   localparam int NREGS_DEF = 32;
   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_INC  = 2'b01,
      OP_DEC  = 2'b10,
      OP_NOP  = 2'b11
   } wr_op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/regfile_wr_alu.sv
// Combinational next-value unit for the write port: load / increment /
// decrement / nop applied to the currently addressed register value.
module regfile_wr_alu
   import regfile_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] nxt
);

   always_comb begin
      nxt = cur;
      case (wr_op_e'(op))
         OP_LOAD: nxt = wr_data;
         OP_INC:  nxt = cur + WIDTH'(1);
         OP_DEC:  nxt = cur - WIDTH'(1);
         default: nxt = cur;
      endcase
   end

endmodule

// File: rtl/regfile32_8bit.sv
// 32 x 8-bit register bank with one valid/ready write port and a
// one-register-per-cycle clear sweep; all registers exposed on regs_flat.
module regfile32_8bit
   import regfile_pkg::*;
#(
   parameter int NREGS   = NREGS_DEF,
   parameter int WIDTH   = WIDTH_DEF,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [4:0]             wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic [1:0]             wr_op,
   input  logic                   clr_req,
   output logic                   clr_busy,
   output logic [NREGS*WIDTH-1:0] regs_flat
);

   state_e           state_q, state_d;
   logic [4:0]       idx_q, idx_d;
   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [WIDTH-1:0] alu_nxt;

   regfile_wr_alu #(.WIDTH(WIDTH)) u_alu (
      .op      (wr_op),
      .cur     (regs_q[wr_addr]),
      .wr_data (wr_data),
      .nxt     (alu_nxt)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      regs_d   = regs_q;
      // A same-cycle clear request blocks the write port.
      wr_ready = (state_q == ST_IDLE) && !clr_req;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d = ST_CLEAR;
               idx_d   = '0;
            end else if (wr_valid) begin
               regs_d[wr_addr] = alu_nxt;
            end
         end
         ST_CLEAR: begin
            regs_d[idx_q] = '0;
            idx_d         = idx_q + 5'd1;
            if (idx_q == 5'(NREGS - 1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (ZERO_R0) regs_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         regs_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         regs_q  <= regs_d;
      end
   end

   assign clr_busy = (state_q == ST_CLEAR);

   for (genvar k = 0; k < NREGS; k++) begin : g_flat
      assign regs_flat[k*WIDTH +: WIDTH] = regs_q[k];
   end

endmodule

// File: tb/tb_regfile32_8bit.sv
// Bench for regfile32_8bit: directed scenarios plus random traffic, checked
// against a byte-array model with a remaining-sweep counter.
module tb_regfile32_8bit;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         wr_valid = 1'b0;
   logic [4:0]   wr_addr = '0;
   logic [7:0]   wr_data = '0;
   logic [1:0]   wr_op = '0;
   logic         clr_req = 1'b0;
   logic         wr_ready, clr_busy, wr_ready_z, clr_busy_z;
   logic [255:0] regs_flat, regs_flat_z;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] m [N];
   int         clr_left;

   always #5 clk = ~clk;

   regfile32_8bit dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_op(wr_op),
      .clr_req(clr_req), .clr_busy(clr_busy), .regs_flat(regs_flat)
   );

   regfile32_8bit #(.ZERO_R0(1'b1)) dut_z (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_z),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_op(wr_op),
      .clr_req(clr_req), .clr_busy(clr_busy_z), .regs_flat(regs_flat_z)
   );

   function automatic logic [255:0] exp_flat(input bit zero_r0);
      logic [255:0] f;
      for (int k = 0; k < N; k++) f[k*8 +: 8] = m[k];
      if (zero_r0) f[7:0] = 8'h00;
      return f;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) m[k] = 8'h00;
      clr_left = 0;
   endtask

   // Advance one clock: inputs are sampled at the rising edge, outputs
   // are examined afterwards at the falling edge.
   task automatic cycle();
      bit acc;
      acc = (clr_left == 0) && !clr_req && wr_valid;
      @(posedge clk);
      if (clr_left > 0) begin
         m[N - clr_left] = 8'h00;
         clr_left--;
      end else if (clr_req) begin
         clr_left = N;
      end else if (acc) begin
         case (wr_op)
            2'b00: m[wr_addr] = wr_data;
            2'b01: m[wr_addr] = m[wr_addr] + 8'd1;
            2'b10: m[wr_addr] = m[wr_addr] - 8'd1;
            default: ;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic do_write(input logic [4:0] a, input logic [7:0] d, input logic [1:0] op);
      wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_op = op;
      cycle();
      wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if (regs_flat !== 256'h0) begin n_bad++; $display("FAIL reset_flat got %h exp 0", regs_flat); end
      n_cmp++;
      if (clr_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", clr_busy); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", wr_ready); end
      @(negedge clk);
   endtask

   task automatic test_load();
      do_write(5'd5, 8'hA7, 2'b00);
      n_cmp++;
      if (regs_flat[47:40] !== 8'hA7) begin n_bad++; $display("FAIL load_r5 got %h exp a7", regs_flat[47:40]); end
      n_cmp++;
      if (regs_flat !== exp_flat(0)) begin n_bad++; $display("FAIL load_flat got %h exp %h", regs_flat, exp_flat(0)); end
   endtask

   task automatic test_wrap();
      do_write(5'd31, 8'hFF, 2'b00);
      do_write(5'd31, 8'h00, 2'b01);
      n_cmp++;
      if (regs_flat[255:248] !== 8'h00) begin n_bad++; $display("FAIL inc_wrap got %h exp 00", regs_flat[255:248]); end
      do_write(5'd2, 8'h00, 2'b00);
      do_write(5'd2, 8'h33, 2'b10);
      n_cmp++;
      if (regs_flat[23:16] !== 8'hFF) begin n_bad++; $display("FAIL dec_wrap got %h exp ff", regs_flat[23:16]); end
      do_write(5'd2, 8'h44, 2'b11);
      n_cmp++;
      if (regs_flat[23:16] !== 8'hFF) begin n_bad++; $display("FAIL nop_hold got %h exp ff", regs_flat[23:16]); end
      n_cmp++;
      if (regs_flat !== exp_flat(0)) begin n_bad++; $display("FAIL wrap_flat got %h exp %h", regs_flat, exp_flat(0)); end
   endtask

   task automatic test_clear();
      int busy_cnt;
      for (int k = 0; k < N; k++) do_write(5'(k), 8'h55, 2'b00);
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      // Write held valid throughout the sweep.
      wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 8'h3C; wr_op = 2'b00;
      busy_cnt = 0;
      while (clr_busy === 1'b1 && busy_cnt < 100) begin
         busy_cnt++;
         n_cmp++;
         if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL clr_ready cyc %0d got %b exp 0", busy_cnt, wr_ready); end
         n_cmp++;
         if (regs_flat !== exp_flat(0)) begin n_bad++; $display("FAIL clr_sweep cyc %0d got %h exp %h", busy_cnt, regs_flat, exp_flat(0)); end
         cycle();
         if (busy_cnt == 1) begin
            n_cmp++;
            if (regs_flat[7:0] !== 8'h00 || regs_flat[15:8] !== 8'h55) begin
               n_bad++; $display("FAIL clr_r0_first got r0=%h r1=%h exp 00/55", regs_flat[7:0], regs_flat[15:8]);
            end
         end
         if (busy_cnt == 31) begin
            n_cmp++;
            if (regs_flat[255:248] !== 8'h55) begin n_bad++; $display("FAIL clr_r31_last got %h exp 55", regs_flat[255:248]); end
         end
      end
      n_cmp++;
      if (busy_cnt != 32) begin n_bad++; $display("FAIL clr_len got %0d exp 32", busy_cnt); end
      n_cmp++;
      if (regs_flat !== 256'h0 || wr_ready !== 1'b1) begin
         n_bad++; $display("FAIL clr_done got flat=%h ready=%b exp 0/1", regs_flat, wr_ready);
      end
      cycle();
      wr_valid = 1'b0;
      n_cmp++;
      if (regs_flat[63:56] !== 8'h3C) begin n_bad++; $display("FAIL clr_held_wr got %h exp 3c", regs_flat[63:56]); end
   endtask

   task automatic test_simul();
      int guard;
      do_write(5'd3, 8'h77, 2'b00);
      clr_req = 1'b1;
      wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 8'h12; wr_op = 2'b00;
      #1;
      n_cmp++;
      if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL simul_ready got %b exp 0", wr_ready); end
      cycle();
      clr_req = 1'b0;
      guard = 0;
      while (clr_busy === 1'b1 && guard < 100) begin guard++; cycle(); end
      n_cmp++;
      if (guard != 32) begin n_bad++; $display("FAIL simul_len got %0d exp 32", guard); end
      n_cmp++;
      if (regs_flat[31:24] !== 8'h00) begin n_bad++; $display("FAIL simul_r3_cleared got %h exp 00", regs_flat[31:24]); end
      cycle();
      wr_valid = 1'b0;
      n_cmp++;
      if (regs_flat[31:24] !== 8'h12) begin n_bad++; $display("FAIL simul_r3_land got %h exp 12", regs_flat[31:24]); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < N; k++) do_write(5'(k), 8'($urandom_range(1, 255)), 2'b00);
      clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
      for (int k = 0; k < 10; k++) cycle();
      n_cmp++;
      if (regs_flat !== exp_flat(0) || clr_busy !== 1'b1) begin
         n_bad++; $display("FAIL mid_pre got %h busy=%b exp %h busy=1", regs_flat, clr_busy, exp_flat(0));
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (regs_flat !== 256'h0 || clr_busy !== 1'b0) begin
         n_bad++; $display("FAIL mid_async got %h busy=%b exp 0 busy=0", regs_flat, clr_busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (wr_ready !== 1'b1 || clr_busy !== 1'b0) begin
         n_bad++; $display("FAIL mid_release got ready=%b busy=%b exp 1/0", wr_ready, clr_busy);
      end
      @(negedge clk);
   endtask

   task automatic test_zero_r0();
      wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 8'hFF; wr_op = 2'b00;
      #1;
      n_cmp++;
      if (wr_ready_z !== 1'b1) begin n_bad++; $display("FAIL z_ready got %b exp 1", wr_ready_z); end
      cycle();
      wr_valid = 1'b0;
      n_cmp++;
      if (regs_flat_z[7:0] !== 8'h00 || regs_flat[7:0] !== 8'hFF) begin
         n_bad++; $display("FAIL z_r0 got z=%h plain=%h exp 00/ff", regs_flat_z[7:0], regs_flat[7:0]);
      end
      do_write(5'd1, 8'h9D, 2'b00);
      n_cmp++;
      if (regs_flat_z[15:8] !== 8'h9D) begin n_bad++; $display("FAIL z_r1 got %h exp 9d", regs_flat_z[15:8]); end
      do_write(5'd0, 8'h00, 2'b10);
      n_cmp++;
      if (regs_flat_z !== exp_flat(1)) begin n_bad++; $display("FAIL z_flat got %h exp %h", regs_flat_z, exp_flat(1)); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_addr  = 5'($urandom);
         wr_data  = 8'($urandom);
         wr_op    = 2'($urandom);
         clr_req  = ($urandom_range(0, 99) == 0);
         cycle();
         n_cmp++;
         if (regs_flat !== exp_flat(0) || clr_busy !== (clr_left > 0)) begin
            n_bad++; $display("FAIL rand %0d got %h busy=%b exp %h", i, regs_flat, clr_busy, exp_flat(0));
         end
         n_cmp++;
         if (regs_flat_z !== exp_flat(1)) begin
            n_bad++; $display("FAIL rand_z %0d got %h exp %h", i, regs_flat_z, exp_flat(1));
         end
      end
      clr_req = 1'b0;
      wr_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_wrap();
      test_clear();
      test_simul();
      test_reset_mid();
      test_zero_r0();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
